// File: rtl/pio_conditioner.sv
// PIO pin conditioner: synchroniser, per-bit glitch filter, loopback, edge flags.
// Define PIO_FILTER_EN to enable the filter_len-driven glitch filter.
module pio_conditioner #(
    parameter int               WIDTH       = 7,
    parameter int               FILTER_BITS = 4,
    parameter logic [WIDTH-1:0] IDLE_LEVEL  = 7'h7F
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       pio_pin_in,
    input  logic [WIDTH-1:0]       pio_oe,
    input  logic [WIDTH-1:0]       pio_out,
    input  logic [FILTER_BITS-1:0] filter_len,
    input  logic [WIDTH-1:0]       edge_clear,
    output logic [WIDTH-1:0]       pio_clean,
    output logic [WIDTH-1:0]       edge_flag,
    output logic                   any_edge
);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] next_clean;

`ifdef PIO_FILTER_EN
    logic [FILTER_BITS-1:0] cnt [WIDTH];
    logic [FILTER_BITS-1:0] lim;

    // A zero length behaves as a one-cycle filter.
    assign lim = (filter_len == '0) ? '0 : filter_len - FILTER_BITS'(1);

    always_comb begin
        next_clean = pio_clean;
        for (int i = 0; i < WIDTH; i++) begin
            if (pio_oe[i])
                next_clean[i] = pio_out[i];
            else if (s2[i] != pio_clean[i] && cnt[i] >= lim)
                next_clean[i] = s2[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < WIDTH; i++)
                cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (pio_oe[i] || s2[i] == pio_clean[i] || cnt[i] >= lim)
                    cnt[i] <= '0;
                else
                    cnt[i] <= cnt[i] + FILTER_BITS'(1);
            end
        end
    end
`else
    logic unused_filter_len;

    assign unused_filter_len = ^filter_len;

    always_comb begin
        next_clean = pio_clean;
        for (int i = 0; i < WIDTH; i++)
            next_clean[i] = pio_oe[i] ? pio_out[i] : s2[i];
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            s1        <= IDLE_LEVEL;
            s2        <= IDLE_LEVEL;
            pio_clean <= IDLE_LEVEL;
            edge_flag <= '0;
        end else begin
            s1        <= pio_pin_in;
            s2        <= s1;
            pio_clean <= next_clean;
            // A change on this edge wins over a same-cycle clear.
            edge_flag <= (next_clean ^ pio_clean) | (edge_flag & ~edge_clear);
        end
    end

    assign any_edge = |edge_flag;

endmodule
